// File: rtl/axis_header_rr_arbiter.sv
// Packet-level round-robin arbiter that feeds one header inserter from NUM_SRC AXI-Stream sources.
// Optional per-source packet counters are enabled with `define AXIS_ARB_PKT_CNT_EN.
module axis_header_rr_arbiter #(
  parameter int NUM_SRC      = 2,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  localparam int GW          = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              s_valid_in,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in,
  input  logic [NUM_SRC-1:0]              s_last_in,
  output logic [NUM_SRC-1:0]              s_ready_in,
  input  logic [NUM_SRC-1:0]              s_valid_insert,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_header_insert,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert,
  output logic [NUM_SRC-1:0]              s_ready_insert,
  output logic                            m_valid_in,
  output logic [DATA_WD-1:0]              m_data_in,
  output logic [DATA_BYTE_WD-1:0]         m_keep_in,
  output logic                            m_last_in,
  input  logic                            m_ready_in,
  output logic                            m_valid_insert,
  output logic [DATA_WD-1:0]              m_header_insert,
  output logic [DATA_BYTE_WD-1:0]         m_keep_insert,
  input  logic                            m_ready_insert,
  output logic [GW-1:0]                   grant,
  output logic                            busy
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  output logic [NUM_SRC*16-1:0]           pkt_cnt
`endif
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] winner;
  logic          any_req;
  logic          hdr_done;
  logic          pkt_end;
  logic          hdr_hs;

  assign pkt_end = (state == PKT) && m_valid_in && m_ready_in && m_last_in;
  assign hdr_hs  = m_valid_insert && m_ready_insert;

  // First requester at or above rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    winner  = rr_ptr;
    any_req = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!any_req && s_valid_insert[(int'(rr_ptr) + k) % NUM_SRC]) begin
        winner  = GW'((int'(rr_ptr) + k) % NUM_SRC);
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= '0;
      rr_ptr   <= '0;
      hdr_done <= 1'b0;
    end else begin
      if (state == IDLE && any_req) grant <= winner;
      if (pkt_end) begin
        rr_ptr   <= (grant == GW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
        hdr_done <= 1'b0;
      end else if (hdr_hs) begin
        hdr_done <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = PKT;
      PKT:     if (pkt_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only the granted source is routed; everything is quiet outside a packet.
  always_comb begin
    busy            = (state == PKT);
    m_valid_in      = 1'b0;
    m_data_in       = '0;
    m_keep_in       = '0;
    m_last_in       = 1'b0;
    m_valid_insert  = 1'b0;
    m_header_insert = '0;
    m_keep_insert   = '0;
    s_ready_in      = '0;
    s_ready_insert  = '0;
    if (state == PKT) begin
      m_valid_in             = s_valid_in[grant];
      m_data_in              = s_data_in[grant*DATA_WD +: DATA_WD];
      m_keep_in              = s_keep_in[grant*DATA_BYTE_WD +: DATA_BYTE_WD];
      m_last_in              = s_last_in[grant];
      s_ready_in[grant]      = m_ready_in;
      m_valid_insert         = s_valid_insert[grant] & ~hdr_done;
      m_header_insert        = s_header_insert[grant*DATA_WD +: DATA_WD];
      m_keep_insert          = s_keep_insert[grant*DATA_BYTE_WD +: DATA_BYTE_WD];
      s_ready_insert[grant]  = m_ready_insert & ~hdr_done;
    end
  end

`ifdef AXIS_ARB_PKT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (pkt_end) begin
      pkt_cnt[grant*16 +: 16] <= pkt_cnt[grant*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_header_rr_arbiter.sv
// Directed self-checking bench for axis_header_rr_arbiter (NUM_SRC=2, DATA_WD=32).
module tb_axis_header_rr_arbiter;

  localparam int NUM_SRC = 2;
  localparam int DW      = 32;
  localparam int KW      = 4;

  logic               clk;
  logic               rst_n;
  logic [1:0]         s_valid_in, s_last_in, s_ready_in;
  logic [1:0]         s_valid_insert, s_ready_insert;
  logic [2*DW-1:0]    s_data_in, s_header_insert;
  logic [2*KW-1:0]    s_keep_in, s_keep_insert;
  logic               m_valid_in, m_last_in, m_ready_in;
  logic               m_valid_insert, m_ready_insert;
  logic [DW-1:0]      m_data_in, m_header_insert;
  logic [KW-1:0]      m_keep_in, m_keep_insert;
  logic               grant;
  logic               busy;
`ifdef AXIS_ARB_PKT_CNT_EN
  logic [NUM_SRC*16-1:0] pkt_cnt;
`endif

  int checks = 0;
  int errors = 0;

  axis_header_rr_arbiter #(.NUM_SRC(NUM_SRC), .DATA_WD(DW), .DATA_BYTE_WD(KW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_valid_in     (s_valid_in),
    .s_data_in      (s_data_in),
    .s_keep_in      (s_keep_in),
    .s_last_in      (s_last_in),
    .s_ready_in     (s_ready_in),
    .s_valid_insert (s_valid_insert),
    .s_header_insert(s_header_insert),
    .s_keep_insert  (s_keep_insert),
    .s_ready_insert (s_ready_insert),
    .m_valid_in     (m_valid_in),
    .m_data_in      (m_data_in),
    .m_keep_in      (m_keep_in),
    .m_last_in      (m_last_in),
    .m_ready_in     (m_ready_in),
    .m_valid_insert (m_valid_insert),
    .m_header_insert(m_header_insert),
    .m_keep_insert  (m_keep_insert),
    .m_ready_insert (m_ready_insert),
    .grant          (grant),
    .busy           (busy)
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    .pkt_cnt        (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    s_valid_in      = '0;
    s_last_in       = '0;
    s_valid_insert  = '0;
    s_data_in       = '0;
    s_header_insert = '0;
    s_keep_in       = '0;
    s_keep_insert   = '0;
    m_ready_in      = 1'b1;
    m_ready_insert  = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_single(input int src);
    @(negedge clk);
    s_valid_insert[src] = 1'b1;
    @(negedge clk);
    s_valid_in[src] = 1'b1;
    s_last_in[src]  = 1'b1;
    @(negedge clk);
    s_valid_insert = '0;
    s_valid_in     = '0;
    s_last_in      = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n           = 1'b0;
    s_valid_in      = 2'b11;
    s_valid_insert  = 2'b11;
    s_data_in       = {32'hD1D1_0000, 32'hD0D0_0000};
    s_header_insert = {32'hC0C0_0001, 32'hC0C0_0000};
    s_keep_in       = 8'hFF;
    s_keep_insert   = 8'hFF;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (m_valid_in !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid_in: got %0b exp 0", m_valid_in); end
    checks++; if (m_valid_insert !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid_insert: got %0b exp 0", m_valid_insert); end
    checks++; if (s_ready_in !== 2'b00) begin errors++; $display("[TB] FAIL reset_s_ready_in: got %b exp 00", s_ready_in); end
    checks++; if (s_ready_insert !== 2'b00) begin errors++; $display("[TB] FAIL reset_s_ready_insert: got %b exp 00", s_ready_insert); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b exp 0", busy); end
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant: got %0b exp 0", grant); end
    checks++; if (m_data_in !== 32'h0) begin errors++; $display("[TB] FAIL reset_m_data_in: got %h exp 0", m_data_in); end
    checks++; if (m_header_insert !== 32'h0) begin errors++; $display("[TB] FAIL reset_m_header: got %h exp 0", m_header_insert); end
    rst_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL release_busy_latency: got %0b exp 0", busy); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL release_busy: got %0b exp 1", busy); end
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL release_grant: got %0b exp 0", grant); end
    checks++; if (m_header_insert !== 32'hC0C0_0000) begin errors++; $display("[TB] FAIL release_header: got %h exp c0c00000", m_header_insert); end
    checks++; if (s_ready_insert !== 2'b01) begin errors++; $display("[TB] FAIL release_s_ready_insert: got %b exp 01", s_ready_insert); end
  endtask

  task automatic test_single_src();
    pulse_reset();
    @(negedge clk);
    s_valid_insert         = 2'b10;
    s_header_insert[63:32] = 32'hA5A5_0001;
    s_keep_insert[7:4]     = 4'b0111;
    s_valid_in             = 2'b10;
    s_data_in[63:32]       = 32'hB100_0000;
    s_keep_in[7:4]         = 4'hF;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL src1_req_busy: got %0b exp 0", busy); end
    checks++; if (s_ready_in !== 2'b00) begin errors++; $display("[TB] FAIL src1_req_s_ready_in: got %b exp 00", s_ready_in); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL src1_busy: got %0b exp 1", busy); end
    checks++; if (grant !== 1'b1) begin errors++; $display("[TB] FAIL src1_grant: got %0b exp 1", grant); end
    checks++; if (m_header_insert !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL src1_header: got %h exp a5a50001", m_header_insert); end
    checks++; if (m_keep_insert !== 4'b0111) begin errors++; $display("[TB] FAIL src1_keep_insert: got %b exp 0111", m_keep_insert); end
    checks++; if (m_valid_insert !== 1'b1) begin errors++; $display("[TB] FAIL src1_m_valid_insert: got %0b exp 1", m_valid_insert); end
    checks++; if (s_ready_insert !== 2'b10) begin errors++; $display("[TB] FAIL src1_s_ready_insert: got %b exp 10", s_ready_insert); end
    checks++; if (s_ready_in !== 2'b10) begin errors++; $display("[TB] FAIL src1_s_ready_in_b0: got %b exp 10", s_ready_in); end
    checks++; if (m_data_in !== 32'hB100_0000) begin errors++; $display("[TB] FAIL src1_data_b0: got %h exp b1000000", m_data_in); end
    @(negedge clk);
    s_valid_insert   = 2'b00;
    s_data_in[63:32] = 32'hB100_0001;
    #1;
    checks++; if (m_valid_insert !== 1'b0) begin errors++; $display("[TB] FAIL src1_hdr_once: got %0b exp 0", m_valid_insert); end
    checks++; if (m_data_in !== 32'hB100_0001) begin errors++; $display("[TB] FAIL src1_data_b1: got %h exp b1000001", m_data_in); end
    checks++; if (s_ready_in !== 2'b10) begin errors++; $display("[TB] FAIL src1_s_ready_in_b1: got %b exp 10", s_ready_in); end
    @(negedge clk);
    s_data_in[63:32] = 32'hB100_0002;
    s_last_in        = 2'b10;
    #1;
    checks++; if (m_last_in !== 1'b1) begin errors++; $display("[TB] FAIL src1_last: got %0b exp 1", m_last_in); end
    checks++; if (m_data_in !== 32'hB100_0002) begin errors++; $display("[TB] FAIL src1_data_b2: got %h exp b1000002", m_data_in); end
    @(negedge clk);
    s_valid_in = 2'b00;
    s_last_in  = 2'b00;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL src1_bubble_busy: got %0b exp 0", busy); end
    checks++; if (m_valid_in !== 1'b0) begin errors++; $display("[TB] FAIL src1_bubble_m_valid_in: got %0b exp 0", m_valid_in); end
  endtask

  task automatic test_round_robin();
    logic [31:0] beat0, beat1;
    logic        exp_g;
    pulse_reset();
    s_header_insert = {32'hC0C0_0001, 32'hC0C0_0000};
    s_keep_in       = 8'hFF;
    s_keep_insert   = 8'hFF;
    for (int p = 0; p < 4; p++) begin
      exp_g = 1'(p % 2);
      beat0 = 32'hE000_0000 | (32'(p) << 8);
      beat1 = beat0 | 32'h1;
      @(negedge clk);
      s_valid_insert = 2'b11;
      s_valid_in     = 2'b00;
      s_last_in      = 2'b00;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_bubble_p%0d: got %0b exp 0", p, busy); end
      @(negedge clk);
      s_valid_in = 2'b11;
      s_data_in  = {32'hDEAD_0001, 32'hDEAD_0000};
      s_data_in[int'(exp_g)*32 +: 32] = beat0;
      #1;
      checks++; if (grant !== exp_g) begin errors++; $display("[TB] FAIL rr_grant_p%0d: got %0b exp %0b", p, grant, exp_g); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rr_busy_p%0d: got %0b exp 1", p, busy); end
      checks++; if (m_data_in !== beat0) begin errors++; $display("[TB] FAIL rr_data0_p%0d: got %h exp %h", p, m_data_in, beat0); end
      checks++; if (m_header_insert !== (32'hC0C0_0000 + 32'(exp_g))) begin errors++; $display("[TB] FAIL rr_header_p%0d: got %h exp %h", p, m_header_insert, 32'hC0C0_0000 + 32'(exp_g)); end
      checks++; if (s_ready_in !== (2'b01 << exp_g)) begin errors++; $display("[TB] FAIL rr_s_ready_in_p%0d: got %b exp %b", p, s_ready_in, 2'b01 << exp_g); end
      @(negedge clk);
      s_valid_insert[exp_g]           = 1'b0;
      s_data_in[int'(exp_g)*32 +: 32] = beat1;
      s_last_in[exp_g]                = 1'b1;
      #1;
      checks++; if (grant !== exp_g) begin errors++; $display("[TB] FAIL rr_grant_hold_p%0d: got %0b exp %0b", p, grant, exp_g); end
      checks++; if (m_data_in !== beat1) begin errors++; $display("[TB] FAIL rr_data1_p%0d: got %h exp %h", p, m_data_in, beat1); end
      checks++; if (m_last_in !== 1'b1) begin errors++; $display("[TB] FAIL rr_last_p%0d: got %0b exp 1", p, m_last_in); end
      checks++; if (m_valid_insert !== 1'b0) begin errors++; $display("[TB] FAIL rr_hdr_once_p%0d: got %0b exp 0", p, m_valid_insert); end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_backpressure();
    pulse_reset();
    s_header_insert = {32'hC0C0_0001, 32'hC0C0_0000};
    @(negedge clk);
    s_valid_insert = 2'b11;
    @(negedge clk);
    s_valid_in = 2'b11;
    s_data_in  = {32'hDEAD_0001, 32'hF000_0000};
    #1;
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL bp_grant_start: got %0b exp 0", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_busy_start: got %0b exp 1", busy); end
    @(negedge clk);
    s_valid_insert  = 2'b10;
    s_data_in[31:0] = 32'hF000_0001;
    m_ready_in      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL bp_grant_c%0d: got %0b exp 0", i, grant); end
      checks++; if (m_data_in !== 32'hF000_0001) begin errors++; $display("[TB] FAIL bp_data_c%0d: got %h exp f0000001", i, m_data_in); end
      checks++; if (s_ready_in !== 2'b00) begin errors++; $display("[TB] FAIL bp_s_ready_in_c%0d: got %b exp 00", i, s_ready_in); end
      checks++; if (s_ready_insert !== 2'b00) begin errors++; $display("[TB] FAIL bp_s_ready_insert_c%0d: got %b exp 00", i, s_ready_insert); end
      @(negedge clk);
    end
    m_ready_in = 1'b1;
    s_last_in  = 2'b01;
    #1;
    checks++; if (s_ready_in !== 2'b01) begin errors++; $display("[TB] FAIL bp_release_s_ready_in: got %b exp 01", s_ready_in); end
    @(negedge clk);
    s_valid_in = 2'b00;
    s_last_in  = 2'b00;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_bubble_busy: got %0b exp 0", busy); end
    @(negedge clk);
    #1;
    checks++; if (grant !== 1'b1) begin errors++; $display("[TB] FAIL bp_next_grant: got %0b exp 1", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_next_busy: got %0b exp 1", busy); end
  endtask

  task automatic test_single_beat();
    pulse_reset();
    s_header_insert[31:0] = 32'hC0C0_0000;
    @(negedge clk);
    s_valid_insert  = 2'b01;
    s_valid_in      = 2'b01;
    s_last_in       = 2'b01;
    s_data_in[31:0] = 32'h5B5B_0000;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL sb_req_busy: got %0b exp 0", busy); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL sb_busy: got %0b exp 1", busy); end
    checks++; if (m_valid_insert !== 1'b1) begin errors++; $display("[TB] FAIL sb_m_valid_insert: got %0b exp 1", m_valid_insert); end
    checks++; if (s_ready_insert !== 2'b01) begin errors++; $display("[TB] FAIL sb_s_ready_insert: got %b exp 01", s_ready_insert); end
    checks++; if (m_last_in !== 1'b1) begin errors++; $display("[TB] FAIL sb_last: got %0b exp 1", m_last_in); end
    checks++; if (s_ready_in !== 2'b01) begin errors++; $display("[TB] FAIL sb_s_ready_in: got %b exp 01", s_ready_in); end
    @(negedge clk);
    s_valid_insert = 2'b00;
    s_valid_in     = 2'b00;
    s_last_in      = 2'b00;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL sb_end_busy: got %0b exp 0", busy); end
    @(negedge clk);
    s_valid_insert = 2'b01;
    s_valid_in     = 2'b01;
    @(negedge clk);
    #1;
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL hold_grant: got %0b exp 0", grant); end
    checks++; if (m_valid_insert !== 1'b1) begin errors++; $display("[TB] FAIL hold_first_hdr: got %0b exp 1", m_valid_insert); end
    @(negedge clk);
    s_last_in = 2'b01;
    #1;
    checks++; if (m_valid_insert !== 1'b0) begin errors++; $display("[TB] FAIL hold_no_reaccept: got %0b exp 0", m_valid_insert); end
    checks++; if (s_ready_insert !== 2'b00) begin errors++; $display("[TB] FAIL hold_s_ready_insert: got %b exp 00", s_ready_insert); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL hold_busy: got %0b exp 1", busy); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_end_busy: got %0b exp 0", busy); end
  endtask

  task automatic test_reset_mid_packet();
    pulse_reset();
    send_single(0);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmp_first_busy: got %0b exp 0", busy); end
`ifdef AXIS_ARB_PKT_CNT_EN
    checks++; if (pkt_cnt !== 32'h0000_0001) begin errors++; $display("[TB] FAIL rmp_cnt_one: got %h exp 00000001", pkt_cnt); end
`endif
    @(negedge clk);
    s_valid_insert = 2'b01;
    @(negedge clk);
    s_valid_in = 2'b01;
    #1;
    checks++; if (m_valid_in !== 1'b1) begin errors++; $display("[TB] FAIL rmp_mid_valid: got %0b exp 1", m_valid_in); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmp_busy: got %0b exp 0", busy); end
    checks++; if (m_valid_in !== 1'b0) begin errors++; $display("[TB] FAIL rmp_m_valid_in: got %0b exp 0", m_valid_in); end
    checks++; if (m_valid_insert !== 1'b0) begin errors++; $display("[TB] FAIL rmp_m_valid_insert: got %0b exp 0", m_valid_insert); end
    checks++; if (s_ready_in !== 2'b00) begin errors++; $display("[TB] FAIL rmp_s_ready_in: got %b exp 00", s_ready_in); end
`ifdef AXIS_ARB_PKT_CNT_EN
    checks++; if (pkt_cnt !== 32'h0) begin errors++; $display("[TB] FAIL rmp_cnt_clear: got %h exp 0", pkt_cnt); end
`endif
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) send_single(0);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmp_after_busy: got %0b exp 0", busy); end
    checks++; if (grant !== 1'b0) begin errors++; $display("[TB] FAIL rmp_after_grant: got %0b exp 0", grant); end
`ifdef AXIS_ARB_PKT_CNT_EN
    checks++; if (pkt_cnt !== 32'h0000_0003) begin errors++; $display("[TB] FAIL rmp_cnt_three: got %h exp 00000003", pkt_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_src();
    test_round_robin();
    test_backpressure();
    test_single_beat();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
